// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: feeds one 32-bit slice per cycle (LSW first) to a 32-bit
// carry-select core, ripples the inter-word carry in a register. Optional OVF_DETECT_EN adds ovf.

module multiword_add_csa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    // Upper half is computed for both possible carries and selected by the lower carry.
    assign lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'b0, cin};
    assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum  = {lo[16] ? hi1[15:0] : hi0[15:0], lo[15:0]};
    assign cout = lo[16] ? hi1[16] : hi0[16];
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4,
    localparam int W = 32 * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
`ifdef OVF_DETECT_EN
    ,
    output logic         ovf
`endif
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic [KW-1:0] k;
    logic [KW+4:0] base;
    logic [31:0]   core_a;
    logic [31:0]   core_b;
    logic [31:0]   core_sum;
    logic          core_cout;

    assign base   = {k, 5'b0};
    assign core_a = a_reg[base +: 32];
    assign core_b = b_reg[base +: 32];

    multiword_add_csa32 u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (carry_reg),
        .sum  (core_sum),
        .cout (core_cout)
    );

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef OVF_DETECT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1; cin is ignored in that case.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        k         <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: 32] <= core_sum;
                    carry_reg       <= core_cout;
                    if (k == K_LAST) begin
                        cout      <= core_cout;
                        out_valid <= 1'b1;
                        k         <= '0;
                        state     <= DONE;
`ifdef OVF_DETECT_EN
                        // Carry into the MSB recovered from the MSB sum bit.
                        ovf <= core_cout ^ (core_a[31] ^ core_b[31] ^ core_sum[31]);
`endif
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed checks of multiword_add_seq at WORDS=4 and WORDS=1 (ovf checked when OVF_DETECT_EN).

module tb_multiword_add_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
    logic [127:0] a, b, sum;
    logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, busy1;
    logic [31:0]  a1, b1, sum1;
`ifdef OVF_DETECT_EN
    logic         ovf4, ovf1;
`endif
    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    multiword_add_seq #(.WORDS(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
`ifdef OVF_DETECT_EN
        , .ovf(ovf4)
`endif
    );

    multiword_add_seq #(.WORDS(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef OVF_DETECT_EN
        , .ovf(ovf1)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the WORDS=4 instance and wait (bounded) for out_valid; lat = edges after accept.
    task automatic op4(input logic [127:0] av, input logic [127:0] bv, input logic c, input logic s);
        check("in_ready_before_op", in_ready, 1'b1);
        a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic pop4();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("pop_out_valid", out_valid, 1'b0);
        check("pop_in_ready", in_ready, 1'b1);
    endtask

    task automatic op1(input logic [31:0] av, input logic [31:0] bv);
        check("w1_in_ready", in_ready1, 1'b1);
        a1 = av; b1 = bv; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid1 && lat < 20);
        check("w1_latency", 128'(lat), 128'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready_low", in_ready, 1'b0);
        rst = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1'b1);
        @(negedge clk);

        // Full carry ripple across all four words.
        op4({128{1'b1}}, 128'd1, 1'b0, 1'b0);
        check("ripple_latency", 128'(lat), 128'd4);
        check("ripple_sum", sum, '0);
        check("ripple_cout", cout, 1'b1);
        check("ripple_busy", busy, 1'b1);
        pop4();

        op4(128'hFFFF_FFFF, 128'd0, 1'b1, 1'b0);
        check("cin_sum", sum, 128'h1_0000_0000);
        check("cin_cout", cout, 1'b0);
        pop4();

        // 5 - 7 wraps; cin is ignored for subtract.
        op4(128'd5, 128'd7, 1'b1, 1'b1);
        check("sub_borrow_sum", sum, {{31{4'hF}}, 4'hE});
        check("sub_borrow_cout", cout, 1'b0);
        pop4();
        op4(128'd7, 128'd5, 1'b0, 1'b1);
        check("sub_sum", sum, 128'd2);
        check("sub_cout", cout, 1'b1);

        // Backpressure: hold DONE, offer a new op that must be ignored.
        a = 128'd100; b = 128'd200; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_sum", sum, 128'd2);
            check("bp_cout", cout, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        pop4();
        check("bp_not_accepted", busy, 1'b0);

        // Reset during the second RUN cycle.
        a = {128{1'b1}}; b = 128'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_out_valid", out_valid, 1'b0);
        check("midrun_sum", sum, '0);
        check("midrun_cout", cout, 1'b0);
        check("midrun_busy", busy, 1'b0);
        rst = 1'b0;
        #1 check("midrun_in_ready", in_ready, 1'b1);
        @(negedge clk);
        op4(128'd3, 128'd4, 1'b0, 1'b0);
        check("post_rst_sum", sum, 128'd7);
        check("post_rst_cout", cout, 1'b0);
        pop4();

        // Single-word instance.
        op1(32'h7FFF_FFFF, 32'd1);
        check("w1_sum_a", 128'(sum1), 128'h8000_0000);
        check("w1_cout_a", cout1, 1'b0);
`ifdef OVF_DETECT_EN
        check("w1_ovf_a", ovf1, 1'b1);
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1_pop", out_valid1, 1'b0);
        op1(32'hFFFF_FFFF, 32'd1);
        check("w1_sum_b", 128'(sum1), 128'd0);
        check("w1_cout_b", cout1, 1'b1);
`ifdef OVF_DETECT_EN
        check("w1_ovf_b", ovf1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
